// File: rtl/signal_status_monitor.sv
// signal_status_monitor
// Debounces the raw activity flag into a signal-present status with
// hysteresis, counts loss-of-signal events, keeps a sticky loss flag and
// emits single-cycle acquire/loss event pulses. All outputs are registered.
module signal_status_monitor #(
  parameter int unsigned C_ACQ  = 1000,
  parameter int unsigned C_HOLD = 100,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             act,
  input  logic             clr_sticky,
  input  logic             clr_cnt,
  output logic             present,
  output logic [1:0]       state,
  output logic             acq_pulse,
  output logic             loss_pulse,
  output logic             lost_sticky,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int unsigned C_MAX = (C_ACQ > C_HOLD) ? C_ACQ : C_HOLD;
  localparam int unsigned TW    = $clog2(C_MAX + 1);

  // Terminal timer values: tmr+1 == C is evaluated as tmr == C-1 so the
  // comparison never needs a bit wider than the timer itself.
  localparam logic [TW-1:0] ACQ_LAST  = TW'(C_ACQ - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(C_HOLD - 1);

  typedef enum logic [1:0] {
    S_LOST    = 2'd0,
    S_ACQ     = 2'd1,
    S_PRESENT = 2'd2,
    S_LOSING  = 2'd3
  } state_t;

  state_t        st;
  logic [TW-1:0] tmr;

  assign state = st;

  // Qualification FSM together with the event pulses, sticky flag and counter.
  // Clears are applied first; a loss event in the same cycle overrides them
  // (sticky set wins, counter restarts at 1 instead of 0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st          <= S_LOST;
      tmr         <= '0;
      present     <= 1'b0;
      acq_pulse   <= 1'b0;
      loss_pulse  <= 1'b0;
      lost_sticky <= 1'b0;
      loss_cnt    <= '0;
    end else begin
      acq_pulse  <= 1'b0;
      loss_pulse <= 1'b0;
      if (clr_sticky) lost_sticky <= 1'b0;
      if (clr_cnt)    loss_cnt    <= '0;

      case (st)
        S_LOST: begin
          if (act) begin
            if (C_ACQ == 1) begin
              st        <= S_PRESENT;
              present   <= 1'b1;
              acq_pulse <= 1'b1;
              tmr       <= '0;
            end else begin
              st  <= S_ACQ;
              tmr <= TW'(1);
            end
          end else begin
            tmr <= '0;
          end
        end

        S_ACQ: begin
          if (!act) begin
            st  <= S_LOST;
            tmr <= '0;
          end else if (tmr == ACQ_LAST) begin
            st        <= S_PRESENT;
            present   <= 1'b1;
            acq_pulse <= 1'b1;
            tmr       <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_PRESENT: begin
          if (!act) begin
            if (C_HOLD == 1) begin
              st          <= S_LOST;
              present     <= 1'b0;
              loss_pulse  <= 1'b1;
              lost_sticky <= 1'b1;
              tmr         <= '0;
              if (clr_cnt)              loss_cnt <= CNT_W'(1);
              else if (loss_cnt != '1)  loss_cnt <= loss_cnt + 1'b1;
            end else begin
              st  <= S_LOSING;
              tmr <= TW'(1);
            end
          end else begin
            tmr <= '0;
          end
        end

        S_LOSING: begin
          if (act) begin
            st  <= S_PRESENT;
            tmr <= '0;
          end else if (tmr == HOLD_LAST) begin
            st          <= S_LOST;
            present     <= 1'b0;
            loss_pulse  <= 1'b1;
            lost_sticky <= 1'b1;
            tmr         <= '0;
            if (clr_cnt)              loss_cnt <= CNT_W'(1);
            else if (loss_cnt != '1)  loss_cnt <= loss_cnt + 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        default: begin
          st      <= S_LOST;
          present <= 1'b0;
          tmr     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signal_status_monitor.sv
// Directed bench for signal_status_monitor: one instance with C_ACQ=8,
// C_HOLD=4, CNT_W=4 and one with C_ACQ=1, C_HOLD=1, CNT_W=4.
module tb_signal_status_monitor;

  logic       clk = 1'b0;
  logic       resetn, act, clr_sticky, clr_cnt;
  logic       present, acq_pulse, loss_pulse, lost_sticky;
  logic [1:0] state;
  logic [3:0] loss_cnt;

  logic       resetn1, act1;
  logic       present1, acq_pulse1, loss_pulse1, lost_sticky1;
  logic [1:0] state1;
  logic [3:0] loss_cnt1;

  int n_pass  = 0;
  int n_total = 0;
  int acq_seen = 0;

  always #5 clk = ~clk;

  signal_status_monitor #(.C_ACQ(8), .C_HOLD(4), .CNT_W(4)) u_dut (
    .clk(clk), .resetn(resetn), .act(act),
    .clr_sticky(clr_sticky), .clr_cnt(clr_cnt),
    .present(present), .state(state), .acq_pulse(acq_pulse),
    .loss_pulse(loss_pulse), .lost_sticky(lost_sticky), .loss_cnt(loss_cnt)
  );

  signal_status_monitor #(.C_ACQ(1), .C_HOLD(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .resetn(resetn1), .act(act1),
    .clr_sticky(1'b0), .clr_cnt(1'b0),
    .present(present1), .state(state1), .acq_pulse(acq_pulse1),
    .loss_pulse(loss_pulse1), .lost_sticky(lost_sticky1), .loss_cnt(loss_cnt1)
  );

  // Count acquire pulses of the main instance, sampled mid-cycle.
  always @(negedge clk) if (acq_pulse === 1'b1) acq_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One active edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic a, input int n);
    act = a;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; act = 1'b0; clr_sticky = 1'b0; clr_cnt = 1'b0;
    resetn1 = 1'b0; act1 = 1'b0;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_present", present, 0);
    chk("rst_acq", acq_pulse, 0);
    chk("rst_loss", loss_pulse, 0);
    chk("rst_sticky", lost_sticky, 0);
    chk("rst_cnt", loss_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    resetn1 = 1'b1;
    tick();
    chk("idle_state", state, 0);

    // Acquire latency: act high from edge 0
    act = 1'b1;
    tick();
    chk("acq_e0_state", state, 1);
    chk("acq_e0_present", present, 0);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("acq_wait_present", present, 0);
      chk("acq_wait_pulse", acq_pulse, 0);
    end
    tick();
    chk("acq_e7_present", present, 1);
    chk("acq_e7_pulse", acq_pulse, 1);
    chk("acq_e7_state", state, 2);
    tick();
    chk("acq_e8_pulse", acq_pulse, 0);
    chk("acq_e8_present", present, 1);

    // Short dropout while present: hysteresis holds
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 1);
      chk("drop_present", present, 1);
      chk("drop_state", state, 3);
      chk("drop_loss", loss_pulse, 0);
    end
    run(1'b1, 1);
    chk("drop_ret_state", state, 2);
    chk("drop_ret_acq", acq_pulse, 0);
    chk("drop_ret_cnt", loss_cnt, 0);

    // Full loss: 4 low samples
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 1);
      chk("loss_wait_pulse", loss_pulse, 0);
      chk("loss_wait_present", present, 1);
    end
    run(1'b0, 1);
    chk("loss_pulse", loss_pulse, 1);
    chk("loss_sticky", lost_sticky, 1);
    chk("loss_cnt", loss_cnt, 1);
    chk("loss_present", present, 0);
    chk("loss_state", state, 0);
    run(1'b0, 1);
    chk("loss_pulse_drop", loss_pulse, 0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("clr_sticky", lost_sticky, 0);
    chk("clr_sticky_cnt", loss_cnt, 1);

    // Interrupted acquisition restarts qualification
    acq_seen = 0;
    run(1'b1, 7);
    chk("restart_state", state, 1);
    chk("restart_present", present, 0);
    run(1'b0, 1);
    chk("restart_lost", state, 0);
    run(1'b1, 7);
    chk("restart_7_present", present, 0);
    run(1'b1, 1);
    chk("restart_8_present", present, 1);
    run(1'b1, 1);
    chk("restart_acq_count", acq_seen, 1);

    // 17 further loss events: counter saturates at 15
    for (int k = 1; k <= 17; k++) begin
      run(1'b0, 4);
      chk("sat_loss_pulse", loss_pulse, 1);
      chk("sat_cnt", loss_cnt, (k + 1 > 15) ? 15 : k + 1);
      run(1'b1, 8);
    end
    chk("sat_present", present, 1);

    // Loss event coinciding with both clears
    run(1'b0, 3);
    clr_cnt = 1'b1; clr_sticky = 1'b1;
    tick();
    clr_cnt = 1'b0; clr_sticky = 1'b0;
    chk("coinc_pulse", loss_pulse, 1);
    chk("coinc_cnt", loss_cnt, 1);
    chk("coinc_sticky", lost_sticky, 1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_cnt_alone", loss_cnt, 0);

    // C_ACQ=1, C_HOLD=1: present follows act one edge later
    for (int i = 0; i < 8; i++) begin
      act1 = (i % 2 == 0);
      tick();
      chk("fast_present", present1, act1);
      chk("fast_acq", acq_pulse1, act1);
      chk("fast_loss", loss_pulse1, !act1);
      chk("fast_state", state1, act1 ? 2 : 0);
    end
    chk("fast_cnt", loss_cnt1, 4);
    chk("fast_sticky", lost_sticky1, 1);
    act1 = 1'b1;
    tick();
    chk("fast_pre_rst", present1, 1);
    #2;
    resetn1 = 1'b0;
    #1;
    chk("arst_present", present1, 0);
    chk("arst_state", state1, 0);
    chk("arst_acq", acq_pulse1, 0);
    chk("arst_loss", loss_pulse1, 0);
    chk("arst_sticky", lost_sticky1, 0);
    chk("arst_cnt", loss_cnt1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/signal_status_monitor.md
# signal_status_monitor

Qualifies the raw activity flag from the upstream signal-activity indicator into a debounced signal-present status with hysteresis. Counts loss-of-signal events, keeps a sticky loss flag and emits single-cycle acquire/loss event pulses. Sits directly downstream of the indicator; its outputs feed the status/interrupt logic.

## Interface
- C_ACQ, 1000: consecutive high `act` samples required to declare signal present; legal range 1..65535.
- C_HOLD, 100: consecutive low `act` samples required to declare signal lost; legal range 1..65535.
- CNT_W, 16: width of the loss-event counter; legal range 1..32.

- clk  in  1  single clock for the whole block.
- resetn  in  1  asynchronous, active-low reset.
- act  in  1  activity flag from the indicator; synchronous to clk; no synchronizer.
- clr_sticky  in  1  when high on a clock edge, clears `lost_sticky`.
- clr_cnt  in  1  when high on a clock edge, clears `loss_cnt`.
- present  out  1  debounced signal-present status.
- state  out  2  FSM state: 0 LOST, 1 ACQ, 2 PRESENT, 3 LOSING.
- acq_pulse  out  1  one-cycle pulse on the transition into PRESENT from ACQ or LOST.
- loss_pulse  out  1  one-cycle pulse on the transition into LOST from LOSING or PRESENT.
- lost_sticky  out  1  set by a loss event; held until `clr_sticky`.
- loss_cnt  out  CNT_W  count of loss events; saturates at all-ones.

## Operation
- The run timer `tmr` counts consecutive qualifying samples. Its width is `$clog2(max(C_ACQ,C_HOLD)+1)`.
- LOST:
  - `act`=1 and C_ACQ=1: go to PRESENT.
  - `act`=1 otherwise: go to ACQ with `tmr`=1.
  - `act`=0: stay in LOST with `tmr`=0.
- ACQ:
  - `act`=0: go to LOST with `tmr`=0. No event is generated.
  - `act`=1 and `tmr`+1 = C_ACQ: go to PRESENT, assert acq event, `tmr`=0.
  - `act`=1 otherwise: `tmr`++.
- PRESENT:
  - `act`=0 and C_HOLD=1: go to LOST, assert loss event.
  - `act`=0 otherwise: go to LOSING with `tmr`=1.
  - `act`=1: stay in PRESENT.
- LOSING:
  - `act`=1: go to PRESENT with `tmr`=0. No acq event is generated.
  - `act`=0 and `tmr`+1 = C_HOLD: go to LOST, assert loss event, `tmr`=0.
  - `act`=0 otherwise: `tmr`++.
- `present` = 1 in PRESENT and LOSING (hysteresis); 0 in LOST and ACQ.
- Loss event, all in the same cycle:
  - `loss_pulse` goes high for one cycle.
  - `lost_sticky` is set.
  - `loss_cnt` increments unless already all-ones.
- Simultaneous events:
  - Loss event with `clr_sticky`: set wins, so `lost_sticky`=1.
  - Loss event with `clr_cnt`: `loss_cnt` becomes 1.
  - `clr_cnt` alone: `loss_cnt` becomes 0.
- `loss_cnt` never wraps.

## Timing
- All outputs are registered.
- Reset values: `state`=LOST, `tmr`=0, `present`=0, `acq_pulse`=0, `loss_pulse`=0, `lost_sticky`=0, `loss_cnt`=0.
- Acquire latency: `act` is first sampled high at edge k and stays high. Then `present` and `acq_pulse` are high after edge k+C_ACQ-1. `acq_pulse` drops after edge k+C_ACQ.
- Loss latency: `act` is first sampled low at edge k (from PRESENT) and stays low. Then `present`=0, `loss_pulse`=1, `lost_sticky`=1 and `loss_cnt`+1 appear after edge k+C_HOLD-1.
- A single opposite sample during ACQ or LOSING restarts qualification from zero.
- `clr_sticky` and `clr_cnt` take effect at the sampling edge, with one-cycle latency to the output.
- Asserting `resetn` low at any time returns every register to its reset value immediately. Any pending qualification is discarded and no pulse is emitted.
- There is no back-pressure: pulses are not held and are lost if the consumer does not sample them.

## Test plan
- Parameters C_ACQ=8, C_HOLD=4, CNT_W=4:
  - Reset, then `act`=1 from edge 0 → `state` ACQ after edge 0, `present`=1 and `acq_pulse`=1 after edge 7, `acq_pulse`=0 after edge 8.
  - `act` high 7 cycles, low 1, high 8 → no acq after the first run; `present` rises 8 cycles after the second run starts; exactly one `acq_pulse`.
  - From PRESENT, `act` low 3 cycles then high → `present` stays 1, `state` returns to PRESENT, no `loss_pulse`, `loss_cnt`=0.
  - From PRESENT, `act` low 4 cycles → `loss_pulse` one cycle, `lost_sticky`=1, `loss_cnt`=1, `present`=0. Then `clr_sticky` → `lost_sticky`=0.
  - Force 17 loss events → `loss_cnt` holds 15. Then a loss event with `clr_cnt` and `clr_sticky` high → `loss_cnt`=1, `lost_sticky`=1.
- Parameters C_ACQ=1, C_HOLD=1: alternate `act` each cycle → `present` tracks `act` delayed one edge, with a pulse on every transition. Then `resetn` low mid-stream → all outputs 0 immediately.
